// File: rtl/branch_rs_param_pkg.sv
// Shared definitions for the branch reservation station.
// Provides the free-tag encoding, zero constants for data/address fields
// and the branch opcode encodings seen by the dispatcher and branch EX.
package branch_rs_param_pkg;

  localparam int BR_OP_W = 6;

  typedef enum logic [BR_OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_BEQ  = 6'd1,
    OP_BNE  = 6'd2,
    OP_BLT  = 6'd3,
    OP_BGE  = 6'd4,
    OP_BLTU = 6'd5,
    OP_BGEU = 6'd6,
    OP_JAL  = 6'd7,
    OP_JALR = 6'd8
  } br_op_e;

  // An operand whose tag equals TAG_FREE already holds its value.
  localparam int unsigned TAG_FREE  = 0;
  localparam int unsigned DATA_FREE = 0;
  localparam int unsigned ADDR_FREE = 0;

endpackage

// File: rtl/branch_rs_param_age_picker.sv
// rs_age_picker: age matrix for the reservation station entries.
// older_q[j][k] = 1 means entry j was dispatched before entry k.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   flush_i         clears the whole matrix
//   alloc_oh_i      one-hot slot written by this cycle's dispatch (0 = none)
//   valid_i         currently valid entries (registered state)
//   ready_i         entries eligible for issue
//   sel_oh_o        one-hot oldest ready entry
//   sel_any_o       at least one entry is ready
module rs_age_picker #(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_oh_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] sel_oh_o,
  output logic             sel_any_o
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // A new entry is younger than every live entry and older than nothing.
  // Rows of freed entries go stale; they are cleared when the slot is reused
  // and never consulted meanwhile because a freed entry is never ready.
  always_comb begin
    older_d = older_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh_i[k]) begin
          older_d[k] = '0;
          for (int j = 0; j < DEPTH; j++) older_d[j][k] = valid_i[j];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  // Entry i wins when no other ready entry is older than it.
  always_comb begin
    sel_oh_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh_o[i] = ready_i[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_i[j] && older_q[j][i]) sel_oh_o[i] = 1'b0;
      end
    end
  end

  assign sel_any_o = |sel_oh_o;

endmodule

// File: rtl/branch_rs_param.sv
// branch_rs_param: branch reservation station.
// Holds dispatched branch ops until both operand tags are satisfied by a CDB
// broadcast, then issues the oldest ready op through a valid/ready issue register.
// Ports:
//   clk, rst (async, active-low), flush (discard everything)
//   cdb_en/cdb_tag/cdb_data   NCDB packed broadcast ports
//   disp_*                    dispatch handshake and op fields
//   iss_*                     issue handshake and op fields
//   free_cnt                  number of free entries
module branch_rs_param
  import branch_rs_param_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  NCDB   = 2,
  parameter int  DATA_W = 32,
  parameter int  TAG_W  = 4,
  parameter int  OP_W   = 6,
  parameter int  ADDR_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NCDB-1:0]        cdb_en,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [OP_W-1:0]        disp_op,
  input  logic [DATA_W-1:0]      disp_imm,
  input  logic [ADDR_W-1:0]      disp_pc,
  input  logic [TAG_W-1:0]       disp_tag_o,
  input  logic [TAG_W-1:0]       disp_tag_t,
  input  logic [DATA_W-1:0]      disp_data_o,
  input  logic [DATA_W-1:0]      disp_data_t,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [OP_W-1:0]        iss_op,
  output logic [DATA_W-1:0]      iss_imm,
  output logic [ADDR_W-1:0]      iss_pc,
  output logic [DATA_W-1:0]      iss_data_o,
  output logic [DATA_W-1:0]      iss_data_t,
  output logic [CNT_W-1:0]       free_cnt
);

  localparam logic [TAG_W-1:0] TAG_Z = TAG_W'(TAG_FREE);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } cdb_res_t;

  // Lowest-index port wins when several ports carry the same tag.
  function automatic cdb_res_t cdb_lookup(input logic [TAG_W-1:0]       tag,
                                          input logic [NCDB-1:0]        en,
                                          input logic [NCDB*TAG_W-1:0]  tags,
                                          input logic [NCDB*DATA_W-1:0] datas);
    cdb_res_t res;
    res = '0;
    if (tag != TAG_Z) begin
      for (int p = NCDB - 1; p >= 0; p--) begin
        if (en[p] && tags[p*TAG_W +: TAG_W] == tag) begin
          res.hit  = 1'b1;
          res.data = datas[p*DATA_W +: DATA_W];
        end
      end
    end
    return res;
  endfunction

  // Entry storage
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [OP_W-1:0]   op_q     [DEPTH];
  logic [OP_W-1:0]   op_d     [DEPTH];
  logic [DATA_W-1:0] imm_q    [DEPTH];
  logic [DATA_W-1:0] imm_d    [DEPTH];
  logic [ADDR_W-1:0] pc_q     [DEPTH];
  logic [ADDR_W-1:0] pc_d     [DEPTH];
  logic [TAG_W-1:0]  tag_o_q  [DEPTH];
  logic [TAG_W-1:0]  tag_o_d  [DEPTH];
  logic [TAG_W-1:0]  tag_t_q  [DEPTH];
  logic [TAG_W-1:0]  tag_t_d  [DEPTH];
  logic [DATA_W-1:0] data_o_q [DEPTH];
  logic [DATA_W-1:0] data_o_d [DEPTH];
  logic [DATA_W-1:0] data_t_q [DEPTH];
  logic [DATA_W-1:0] data_t_d [DEPTH];

  logic [DEPTH-1:0] free_oh, alloc_oh, rdy, sel_oh;
  logic             sel_any, disp_fire, iss_load, iss_take;
  logic [CNT_W-1:0] n_vld;

  // Free-slot priority encoder and occupancy, from registered state only.
  always_comb begin
    free_oh = '0;
    n_vld   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_oh = DEPTH'(1) << i;
    end
    for (int i = 0; i < DEPTH; i++) n_vld = n_vld + CNT_W'(vld_q[i]);
  end

  assign free_cnt   = CNT_W'(DEPTH) - n_vld;
  assign disp_ready = (n_vld != CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign alloc_oh   = disp_fire ? free_oh : '0;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = vld_q[i] && (tag_o_q[i] == TAG_Z) && (tag_t_q[i] == TAG_Z);
    end
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_age (
    .clk_i     (clk),
    .rst_ni    (rst),
    .flush_i   (flush),
    .alloc_oh_i(alloc_oh),
    .valid_i   (vld_q),
    .ready_i   (rdy),
    .sel_oh_o  (sel_oh),
    .sel_any_o (sel_any)
  );

  assign iss_load = !iss_valid || iss_ready;
  assign iss_take = iss_load && sel_any && !flush;

  // Entry next state: wakeup, free on issue, allocate with CDB bypass.
  always_comb begin
    cdb_res_t w_o, w_t;
    w_o      = '0;
    w_t      = '0;
    vld_d    = vld_q;
    op_d     = op_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    tag_o_d  = tag_o_q;
    tag_t_d  = tag_t_q;
    data_o_d = data_o_q;
    data_t_d = data_t_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        w_o = cdb_lookup(tag_o_q[i], cdb_en, cdb_tag, cdb_data);
        w_t = cdb_lookup(tag_t_q[i], cdb_en, cdb_tag, cdb_data);
        if (vld_q[i] && w_o.hit) begin
          tag_o_d[i]  = TAG_Z;
          data_o_d[i] = w_o.data;
        end
        if (vld_q[i] && w_t.hit) begin
          tag_t_d[i]  = TAG_Z;
          data_t_d[i] = w_t.data;
        end
      end
      if (iss_take) vld_d = vld_d & ~sel_oh;
      // The allocated slot is free in registered state, so it never collides
      // with the wakeup or issue updates above.
      w_o = cdb_lookup(disp_tag_o, cdb_en, cdb_tag, cdb_data);
      w_t = cdb_lookup(disp_tag_t, cdb_en, cdb_tag, cdb_data);
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          vld_d[i]    = 1'b1;
          op_d[i]     = disp_op;
          imm_d[i]    = disp_imm;
          pc_d[i]     = disp_pc;
          tag_o_d[i]  = w_o.hit ? TAG_Z : disp_tag_o;
          tag_t_d[i]  = w_t.hit ? TAG_Z : disp_tag_t;
          data_o_d[i] = w_o.hit ? w_o.data : disp_data_o;
          data_t_d[i] = w_t.hit ? w_t.data : disp_data_t;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_q <= '0;
    else      vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      op_q[i]     <= op_d[i];
      imm_q[i]    <= imm_d[i];
      pc_q[i]     <= pc_d[i];
      tag_o_q[i]  <= tag_o_d[i];
      tag_t_q[i]  <= tag_t_d[i];
      data_o_q[i] <= data_o_d[i];
      data_t_q[i] <= data_t_d[i];
    end
  end

  // Issue register
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_imm, sel_do, sel_dt;
  logic [ADDR_W-1:0] sel_pc;

  always_comb begin
    sel_op  = '0;
    sel_imm = '0;
    sel_pc  = '0;
    sel_do  = '0;
    sel_dt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        sel_op  = op_q[i];
        sel_imm = imm_q[i];
        sel_pc  = pc_q[i];
        sel_do  = data_o_q[i];
        sel_dt  = data_t_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid  <= 1'b0;
      iss_op     <= OP_W'(OP_NOP);
      iss_imm    <= DATA_W'(DATA_FREE);
      iss_pc     <= ADDR_W'(ADDR_FREE);
      iss_data_o <= DATA_W'(DATA_FREE);
      iss_data_t <= DATA_W'(DATA_FREE);
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (iss_load) begin
      iss_valid <= sel_any;
      if (sel_any) begin
        iss_op     <= sel_op;
        iss_imm    <= sel_imm;
        iss_pc     <= sel_pc;
        iss_data_o <= sel_do;
        iss_data_t <= sel_dt;
      end
    end
  end

  // Dispatching into a full station drops the op; the dispatcher must not do it.
  a_no_disp_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(disp_valid && !disp_ready));

endmodule
